act_seq_pipe: RTL and testbench

Parametrised successor of the single-register ACT sequential cell. It keeps the 4:1 select logic (S1 = A1|B1, S0 = A0&B0 choosing D00/D01/D10/D11) and feeds the selected word into a DEPTH-stage valid/ready pipeline. The pipeline has per-stage occupancy, backpressure, flush and an occupancy count. It sits between combinational ACT-style cells and downstream consumers that may stall.

---
 rtl/act_pkg.sv | 22 ++
 rtl/act_pipe_stage.sv | 56 +++++
 rtl/act_seq_pipe.sv | 124 ++++++++++++
 tb/tb_act_seq_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
`default_nettype none
// ============================================================================
// Module      : act_pkg
// Description : Select encoding shared by the ACT-style mux and its pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package act_pkg;

  // {S1,S0} codes naming which candidate word is routed to the pipeline
  localparam logic [1:0] SEL_D00 = 2'b00;
  localparam logic [1:0] SEL_D01 = 2'b01;
  localparam logic [1:0] SEL_D10 = 2'b10;
  localparam logic [1:0] SEL_D11 = 2'b11;

  // ACT select terms: S1 is an OR of its pair, S0 is an AND of its pair
  function automatic logic [1:0] act_sel(input logic a1, input logic b1,
                                         input logic a0, input logic b0);
    return {a1 | b1, a0 & b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : act_pipe_stage
// Description : One valid/ready pipeline slot. Loads when its upstream hands
//               a word over, empties when its word moves downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module act_pipe_stage #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         FLUSH,
  input  logic         up_valid,   // upstream moves (or input accepts) into us
  input  logic [N-1:0] up_data,
  input  logic         dn_free,    // downstream can take our word this cycle
  output logic         v,
  output logic [N-1:0] d,
  output logic         free
);

  logic         v_q, v_d;
  logic [N-1:0] d_q, d_d;

  // Next-state: flush drops occupancy only, a load wins over a departure
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (FLUSH) begin
      v_d = 1'b0;
    end else if (up_valid) begin
      v_d = 1'b1;
      d_d = up_data;
    end else if (v_q && dn_free) begin
      v_d = 1'b0;
    end
  end

  // State register with synchronous active-low clear of valid and data
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v    = v_q;
  assign d    = d_q;
  // A slot can take a new word if it is empty or its word leaves this cycle
  assign free = !v_q || dn_free;

endmodule
`default_nettype wire

// File: rtl/act_seq_pipe.sv
`default_nettype none
// ============================================================================
// Module      : act_seq_pipe
// Description : ACT 4:1 select feeding a DEPTH-stage valid/ready pipeline with
//               backpressure, flush and a registered occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module act_seq_pipe
  import act_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [N-1:0]     D00,
  input  logic [N-1:0]     D01,
  input  logic [N-1:0]     D10,
  input  logic [N-1:0]     D11,
  input  logic             A1,
  input  logic             B1,
  input  logic             A0,
  input  logic             B0,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [N-1:0]     OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             FLUSH,
  output logic [CNT_W-1:0] OCC,
  output logic [1:0]       SEL
);

  logic [1:0]       w_sel;
  logic [N-1:0]     w_mux;
  logic             w_accept;
  logic             w_drain;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign w_sel = act_sel(A1, B1, A0, B0);
  assign SEL   = w_sel;

  // 4:1 candidate select, sampled by the pipeline only on an accepting edge
  always_comb begin
    w_mux = D00;
    case (w_sel)
      SEL_D00: w_mux = D00;
      SEL_D01: w_mux = D01;
      SEL_D10: w_mux = D10;
      SEL_D11: w_mux = D11;
      default: w_mux = D00;
    endcase
  end

  // Stage chain; free ripples back combinationally from OUT_READY
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         v_k;
    logic         free_k;
    logic         up_k;
    logic         dn_k;
    logic [N-1:0] d_k;
    logic [N-1:0] din_k;

    if (k == 0) begin : g_head
      assign up_k  = w_accept;
      assign din_k = w_mux;
    end else begin : g_body
      // previous stage moves into this one
      assign up_k  = g_stage[k-1].v_k && free_k;
      assign din_k = g_stage[k-1].d_k;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_k = OUT_READY;
    end else begin : g_link
      assign dn_k = g_stage[k+1].free_k;
    end

    act_pipe_stage #(
      .N(N)
    ) u_stage (
      .CLK      (CLK),
      .CLR      (CLR),
      .FLUSH    (FLUSH),
      .up_valid (up_k),
      .up_data  (din_k),
      .dn_free  (dn_k),
      .v        (v_k),
      .d        (d_k),
      .free     (free_k)
    );
  end

  assign IN_READY  = g_stage[0].free_k && !FLUSH;
  assign w_accept  = IN_VALID && IN_READY;
  assign OUT_VALID = g_stage[DEPTH-1].v_k;
  assign OUT_DATA  = g_stage[DEPTH-1].d_k;
  // Bubbles move without changing the count, so only the ends matter
  assign w_drain   = OUT_VALID && OUT_READY;

  // Occupancy next-state: +1 on accept, -1 on drain, zero on flush
  always_comb begin
    occ_d = occ_q;
    if (FLUSH) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CNT_W'(w_accept) - CNT_W'(w_drain);
    end
  end

  // Occupancy register, updated on the same edge as the stage valid bits
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_act_seq_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_seq_pipe
// Description : Directed self-checking bench for act_seq_pipe (DEPTH=4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_seq_pipe;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          CLR, FLUSH, A1, B1, A0, B0;
  logic          IN_VALID, OUT_READY, IN_VALID1, OUT_READY1;
  logic [N-1:0]  D00, D01, D10, D11;
  logic          IN_READY, OUT_VALID;
  logic [N-1:0]  OUT_DATA;
  logic [CW-1:0] OCC;
  logic [1:0]    SEL;
  logic          IN_READY1, OUT_VALID1;
  logic [N-1:0]  OUT_DATA1;
  logic          OCC1;
  logic [1:0]    SEL1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  act_seq_pipe #(.N(N), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .CLR(CLR), .D00(D00), .D01(D01), .D10(D10), .D11(D11),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .FLUSH(FLUSH), .OCC(OCC), .SEL(SEL)
  );

  act_seq_pipe #(.N(N), .DEPTH(1)) u_dut1 (
    .CLK(CLK), .CLR(CLR), .D00(D00), .D01(D01), .D10(D10), .D11(D11),
    .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .IN_VALID(IN_VALID1), .IN_READY(IN_READY1),
    .OUT_DATA(OUT_DATA1), .OUT_VALID(OUT_VALID1), .OUT_READY(OUT_READY1),
    .FLUSH(FLUSH), .OCC(OCC1), .SEL(SEL1)
  );

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    IN_VALID1 = 1'b0; OUT_READY1 = 1'b1;
    A1 = 1'b0; B1 = 1'b0; A0 = 1'b0; B0 = 1'b0;
    D00 = 8'hAA; D01 = 8'hBB; D10 = 8'hCC; D11 = 8'hDD;
    tick();
    tick();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID); end
    n_cmp++; if (OUT_DATA !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", OUT_DATA); end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", OCC); end
    n_cmp++; if (OUT_VALID1 !== 1'b0) begin n_err++; $display("FAIL reset_d1_valid: got %b want 0", OUT_VALID1); end
    CLR = 1'b1;
    IN_VALID = 1'b0;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", IN_READY); end
  endtask

  task automatic test_select();
    logic [3:0] pat [4];
    logic [1:0] esel [4];
    logic [7:0] eout [4];
    pat[0] = 4'b0000; esel[0] = 2'b00; eout[0] = 8'h11;
    pat[1] = 4'b0011; esel[1] = 2'b01; eout[1] = 8'h22;
    pat[2] = 4'b1000; esel[2] = 2'b10; eout[2] = 8'h33;
    pat[3] = 4'b0111; esel[3] = 2'b11; eout[3] = 8'h44;
    D00 = 8'h11; D01 = 8'h22; D10 = 8'h33; D11 = 8'h44;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {A1, B1, A0, B0} = pat[i];
      IN_VALID = 1'b1;
      #1;
      n_cmp++; if (SEL !== esel[i]) begin n_err++; $display("FAIL sel_%0d: got %b want %b", i, SEL, esel[i]); end
      tick();
      if (i < 3) begin
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL sel_latency_%0d: got valid %b want 0", i, OUT_VALID); end
      end
    end
    IN_VALID = 1'b0;
    {A1, B1, A0, B0} = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== eout[i]) begin
        n_err++; $display("FAIL sel_out_%0d: got v=%b d=%h want v=1 d=%h", i, OUT_VALID, OUT_DATA, eout[i]);
      end
      tick();
    end
    n_cmp++; if (OUT_VALID !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL sel_empty: got v=%b occ=%0d want v=0 occ=0", OUT_VALID, OCC); end
  endtask

  task automatic test_backpressure();
    OUT_READY = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      D00 = 8'(w);
      IN_VALID = 1'b1;
      #1;
      n_cmp++; if (IN_READY !== (w <= 4)) begin n_err++; $display("FAIL bp_in_ready_%0d: got %b want %b", w, IN_READY, (w <= 4)); end
      if (w <= 4) tick();
    end
    n_cmp++; if (OCC !== 3'd4) begin n_err++; $display("FAIL bp_occ_full: got %0d want 4", OCC); end
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'd1) begin n_err++; $display("FAIL bp_out_1: got v=%b d=%0d want v=1 d=1", OUT_VALID, OUT_DATA); end
    // word 5 still offered; full pipe with consumer ready takes it
    OUT_READY = 1'b1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL bp_full_ready: got %b want 1", IN_READY); end
    tick();
    IN_VALID = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'(e)) begin
        n_err++; $display("FAIL bp_out_%0d: got v=%b d=%0d want v=1 d=%0d", e, OUT_VALID, OUT_DATA, e);
      end
      tick();
    end
    n_cmp++; if (OUT_VALID !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", OUT_VALID, OCC); end
  endtask

  task automatic test_full_stream();
    logic [7:0] exp;
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D00 = 8'(8'h40 + i);
      IN_VALID = 1'b1;
      tick();
    end
    n_cmp++; if (OCC !== 3'd4) begin n_err++; $display("FAIL fs_fill: got %0d want 4", OCC); end
    OUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      D00 = 8'(8'h50 + i);
      #1;
      exp = (i < 4) ? 8'(8'h40 + i) : 8'(8'h50 + i - 4);
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp || IN_READY !== 1'b1) begin
        n_err++; $display("FAIL fs_stream_%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1", i, OUT_VALID, OUT_DATA, IN_READY, exp);
      end
      tick();
      n_cmp++; if (OCC !== 3'd4) begin n_err++; $display("FAIL fs_occ_%0d: got %0d want 4", i, OCC); end
    end
    IN_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h56 + i);
      n_cmp++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== exp) begin
        n_err++; $display("FAIL fs_drain_%0d: got v=%b d=%h want v=1 d=%h", i, OUT_VALID, OUT_DATA, exp);
      end
      tick();
    end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL fs_empty: got %0d want 0", OCC); end
  endtask

  task automatic test_flush();
    int seen;
    OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D00 = 8'(8'h61 + i);
      IN_VALID = 1'b1;
      tick();
    end
    n_cmp++; if (OCC !== 3'd3) begin n_err++; $display("FAIL fl_occ3: got %0d want 3", OCC); end
    FLUSH = 1'b1; D00 = 8'h77; OUT_READY = 1'b1;
    #1;
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL fl_in_ready: got %b want 0", IN_READY); end
    tick();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    n_cmp++; if (OCC !== 3'd0 || OUT_VALID !== 1'b0) begin n_err++; $display("FAIL fl_cleared: got occ=%0d v=%b want occ=0 v=0", OCC, OUT_VALID); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (OUT_VALID === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL fl_no_emit: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      D00 = 8'(8'h81 + i);
      IN_VALID = 1'b1;
      tick();
    end
    IN_VALID = 1'b0;
    n_cmp++; if (OCC !== 3'd4 || OUT_DATA !== 8'h81) begin n_err++; $display("FAIL rm_full: got occ=%0d d=%h want occ=4 d=81", OCC, OUT_DATA); end
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    n_cmp++;
    if (OCC !== 3'd0 || OUT_DATA !== 8'h00 || OUT_VALID !== 1'b0) begin
      n_err++; $display("FAIL rm_cleared: got occ=%0d d=%h v=%b want occ=0 d=00 v=0", OCC, OUT_DATA, OUT_VALID);
    end
  endtask

  task automatic test_depth1();
    IN_VALID = 1'b0;
    OUT_READY1 = 1'b0;
    {A1, B1, A0, B0} = 4'b0000;
    D00 = 8'h11; D10 = 8'h33;
    IN_VALID1 = 1'b1;
    #1;
    n_cmp++; if (IN_READY1 !== 1'b1) begin n_err++; $display("FAIL d1_ready_empty: got %b want 1", IN_READY1); end
    tick();
    n_cmp++; if (OUT_VALID1 !== 1'b1 || OUT_DATA1 !== 8'h11 || OCC1 !== 1'b1) begin n_err++; $display("FAIL d1_first: got v=%b d=%h occ=%0d want v=1 d=11 occ=1", OUT_VALID1, OUT_DATA1, OCC1); end
    A1 = 1'b1;
    #1;
    n_cmp++; if (SEL1 !== 2'b10 || IN_READY1 !== 1'b0) begin n_err++; $display("FAIL d1_full: got sel=%b rdy=%b want sel=10 rdy=0", SEL1, IN_READY1); end
    tick();
    n_cmp++; if (OUT_DATA1 !== 8'h11) begin n_err++; $display("FAIL d1_stall: got %h want 11", OUT_DATA1); end
    OUT_READY1 = 1'b1;
    #1;
    n_cmp++; if (IN_READY1 !== 1'b1) begin n_err++; $display("FAIL d1_ready_drain: got %b want 1", IN_READY1); end
    tick();
    n_cmp++; if (OUT_VALID1 !== 1'b1 || OUT_DATA1 !== 8'h33 || OCC1 !== 1'b1) begin n_err++; $display("FAIL d1_second: got v=%b d=%h occ=%0d want v=1 d=33 occ=1", OUT_VALID1, OUT_DATA1, OCC1); end
    IN_VALID1 = 1'b0;
    A1 = 1'b0;
    tick();
    n_cmp++; if (OUT_VALID1 !== 1'b0 || OCC1 !== 1'b0) begin n_err++; $display("FAIL d1_empty: got v=%b occ=%0d want v=0 occ=0", OUT_VALID1, OCC1); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_full_stream();
    test_flush();
    test_reset_mid();
    test_depth1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
